// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// FSM state encoding and funct3 access size/sign codes.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane merge for stores and lane extract/extend for loads.
// Unlisted funct3 codes fall through to full-word behaviour.
module dcache_lane_align
    import dcache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic        is_b;
    logic        is_h;
    logic        uns;
    logic [7:0]  b;
    logic [15:0] h;

    // Decode access size and signedness
    always_comb begin
        is_b = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h = (funct3 == F3_H) || (funct3 == F3_HU);
        uns  = (funct3 == F3_BU) || (funct3 == F3_HU);
    end

    // Store merge: replace only the addressed lanes
    always_comb begin
        merged = old_word;
        unique case (1'b1)
            is_b: merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
            is_h: merged[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged = store_data;
        endcase
    end

    // Load extract with sign or zero extension
    always_comb begin
        b = old_word[{byte_off, 3'b000} +: 8];
        h = old_word[{byte_off[1], 4'b0000} +: 16];
        unique case (1'b1)
            is_b: load_data = uns ? {24'b0, b} : {{24{b[7]}}, b};
            is_h: load_data = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache.
// Hits complete combinationally; misses write back then refill a line.
module dcache
    import dcache_pkg::*;
#(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteD_i,
    input  logic        Mread_i,
    input  logic        Mwrite_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ReadD_o,
    output logic        DMemReady_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemWData_o,
    output logic        MemReq_o,
    output logic        MemWe_o,
    input  logic [31:0] MemRData_i,
    input  logic        MemAck_i
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    logic [OFF_W-1:0] word;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [31:0]      data_arr [SETS][WORDS_PER_LINE];

    state_t           state;
    state_t           state_nx;
    logic [OFF_W-1:0] k;

    logic        req;
    logic        hit;
    logic        st_hit;
    logic        fill_last;
    logic [31:0] cur_word;
    logic [31:0] merged;
    logic [31:0] load_data;

    assign word = Addr_i[2 +: OFF_W];
    assign idx  = Addr_i[2 + OFF_W +: IDX_W];
    assign tag  = Addr_i[31 -: TAG_W];

    assign req       = Mread_i | Mwrite_i;
    assign hit       = valid[idx] && (tag_arr[idx] == tag);
    assign st_hit    = (state == IDLE) && Mwrite_i && hit;
    assign fill_last = (state == REFILL) && MemAck_i && (&k);
    assign cur_word  = data_arr[idx][word];

    dcache_lane_align u_align (
        .funct3     (funct3_i),
        .byte_off   (Addr_i[1:0]),
        .old_word   (cur_word),
        .store_data (WriteD_i),
        .merged     (merged),
        .load_data  (load_data)
    );

    // Next-state and all CPU/memory-side outputs
    always_comb begin
        state_nx    = state;
        DMemReady_o = 1'b0;
        ReadD_o     = 32'h0;
        MemReq_o    = 1'b0;
        MemWe_o     = 1'b0;
        MemAddr_o   = 32'h0;
        MemWData_o  = 32'h0;
        case (state)
            IDLE: begin
                if (!req) begin
                    DMemReady_o = 1'b1;
                end else if (hit) begin
                    DMemReady_o = 1'b1;
                    if (!Mwrite_i) ReadD_o = load_data;
                end else if (valid[idx] && dirty[idx]) begin
                    state_nx = WRITEBACK;
                end else begin
                    state_nx = REFILL;
                end
            end
            WRITEBACK: begin
                MemReq_o   = 1'b1;
                MemWe_o    = 1'b1;
                MemAddr_o  = {tag_arr[idx], idx, k, 2'b00};
                MemWData_o = data_arr[idx][k];
                if (MemAck_i && (&k)) state_nx = REFILL;
            end
            REFILL: begin
                MemReq_o  = 1'b1;
                MemAddr_o = {tag, idx, k, 2'b00};
                if (MemAck_i && (&k)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    // Transfer counter advances only on acknowledged transfers
    always_ff @(posedge clk_i) begin
        if (!rst_i)                          k <= '0;
        else if (state != IDLE && MemAck_i)  k <= k + 1'b1;
    end

    // Valid and dirty bits
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (st_hit) begin
            dirty[idx] <= 1'b1;
        end else if (fill_last) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end
    end

    // Data and tag arrays, not reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (st_hit) data_arr[idx][word] <= merged;
            if (state == REFILL && MemAck_i) data_arr[idx][k] <= MemRData_i;
            if (fill_last) tag_arr[idx] <= tag;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random
// accesses checked against a flat-memory and tag-presence model.
module tb_dcache;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteD_i;
    logic        Mread_i;
    logic        Mwrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] ReadD_o;
    logic        DMemReady_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWData_o;
    logic        MemReq_o;
    logic        MemWe_o;
    logic [31:0] MemRData_i;
    logic        MemAck_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;

    logic [31:0] bmem    [16384];
    logic [31:0] ref_mem [16384];
    logic        mvalid  [16];
    logic        mdirty  [16];
    logic [23:0] mtag    [16];

    logic        wl_we   [$];
    logic [31:0] wl_addr [$];
    logic [31:0] wl_data [$];

    dcache dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .Addr_i      (Addr_i),
        .WriteD_i    (WriteD_i),
        .Mread_i     (Mread_i),
        .Mwrite_i    (Mwrite_i),
        .funct3_i    (funct3_i),
        .ReadD_o     (ReadD_o),
        .DMemReady_o (DMemReady_o),
        .MemAddr_o   (MemAddr_o),
        .MemWData_o  (MemWData_o),
        .MemReq_o    (MemReq_o),
        .MemWe_o     (MemWe_o),
        .MemRData_i  (MemRData_i),
        .MemAck_i    (MemAck_i)
    );

    always #5 clk = ~clk;

    assign MemRData_i = bmem[MemAddr_o[15:2]];

    always begin
        @(posedge clk);
        #2;
        case (ack_mode)
            0:       MemAck_i = 1'b1;
            1:       MemAck_i = ($urandom_range(0, 3) != 0);
            default: MemAck_i = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        if (rst_i && MemReq_o && MemAck_i) begin
            if (MemWe_o) bmem[MemAddr_o[15:2]] <= MemWData_o;
            wl_we.push_back(MemWe_o);
            wl_addr.push_back(MemAddr_o);
            wl_data.push_back(MemWData_o);
        end
    end

    function automatic logic [31:0] init_word(int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] lane_mask(logic [2:0] f3, logic [1:0] off,
                                              output int sh);
        if (f3 == 3'd0 || f3 == 3'd4) begin
            sh = off * 8;
            return 32'hFF << sh;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            sh = (off / 2) * 16;
            return 32'hFFFF << sh;
        end
        sh = 0;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] old, logic [31:0] wd,
                                              logic [2:0] f3, logic [1:0] off);
        int sh;
        logic [31:0] m;
        m = lane_mask(f3, off, sh);
        return (old & ~m) | ((wd << sh) & m);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f3,
                                             logic [1:0] off);
        int sh;
        logic [31:0] m;
        logic [31:0] v;
        m = lane_mask(f3, off, sh);
        v = (w & m) >> sh;
        if (f3 == 3'd0 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
        if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = '0;
        end
        for (int i = 0; i < 16384; i++) ref_mem[i] = bmem[i];
    endtask

    task automatic do_reset();
        rst_i    = 1'b0;
        Mread_i  = 1'b0;
        Mwrite_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Called at a negedge; returns with requests dropped at a later negedge
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rdata, output int cyc);
        wl_we.delete();
        wl_addr.delete();
        wl_data.delete();
        Addr_i   = a;
        WriteD_i = wd;
        funct3_i = f3;
        Mread_i  = rd;
        Mwrite_i = wr;
        cyc = 0;
        #1;
        while (!DMemReady_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        if (cyc >= 200) chk("access_timeout", 32'(cyc), 32'd0);
        rdata = ReadD_o;
        @(negedge clk);
        Mread_i  = 1'b0;
        Mwrite_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          cnt;

        for (int i = 0; i < 16384; i++) bmem[i] = init_word(i);
        rst_i    = 1'b0;
        Addr_i   = '0;
        WriteD_i = '0;
        Mread_i  = 1'b0;
        Mwrite_i = 1'b0;
        funct3_i = 3'b010;
        ack_mode = 0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_ready",  32'(DMemReady_o), 32'd1);
        chk("rst_req",    32'(MemReq_o),    32'd0);
        chk("rst_we",     32'(MemWe_o),     32'd0);
        chk("rst_maddr",  MemAddr_o,        32'd0);
        chk("rst_mwdata", MemWData_o,       32'd0);
        chk("rst_readd",  ReadD_o,          32'd0);
        @(negedge clk);

        // Cold miss: four refill reads then hit
        access(1, 0, 32'h100, 0, 3'b010, rd, cyc);
        chk("lw100_cyc",  32'(cyc), 32'd5);
        chk("lw100_data", rd, init_word(32'h40));
        chk("lw100_nxf",  32'(wl_we.size()), 32'd4);
        for (int i = 0; i < 4 && i < wl_we.size(); i++) begin
            chk("lw100_we",   32'(wl_we[i]), 32'd0);
            chk("lw100_addr", wl_addr[i], 32'h100 + 32'(i * 4));
        end

        // Store hit, then load it back
        access(0, 1, 32'h104, 32'hDEADBEEF, 3'b010, rd, cyc);
        chk("sw104_cyc", 32'(cyc), 32'd0);
        chk("sw104_nxf", 32'(wl_we.size()), 32'd0);
        access(1, 0, 32'h104, 0, 3'b010, rd, cyc);
        chk("lw104_cyc",  32'(cyc), 32'd0);
        chk("lw104_data", rd, 32'hDEADBEEF);

        // Conflict miss on dirty line: writeback then refill
        access(1, 0, 32'h1100, 0, 3'b010, rd, cyc);
        chk("lw1100_cyc",  32'(cyc), 32'd9);
        chk("lw1100_data", rd, init_word(32'h440));
        chk("lw1100_nxf",  32'(wl_we.size()), 32'd8);
        for (int i = 0; i < 8 && i < wl_we.size(); i++) begin
            if (i < 4) begin
                chk("wb_we",   32'(wl_we[i]), 32'd1);
                chk("wb_addr", wl_addr[i], 32'h100 + 32'(i * 4));
                chk("wb_data", wl_data[i],
                    (i == 1) ? 32'hDEADBEEF : init_word(32'h40 + i));
            end else begin
                chk("rf_we",   32'(wl_we[i]), 32'd0);
                chk("rf_addr", wl_addr[i], 32'h1100 + 32'((i - 4) * 4));
            end
        end

        // Lane extraction and extension
        access(0, 1, 32'h1104, 32'h80FF7F01, 3'b010, rd, cyc);
        access(1, 0, 32'h1107, 0, 3'b000, rd, cyc);
        chk("lb3",  rd, 32'hFFFFFF80);
        access(1, 0, 32'h1107, 0, 3'b100, rd, cyc);
        chk("lbu3", rd, 32'h00000080);
        access(1, 0, 32'h1104, 0, 3'b001, rd, cyc);
        chk("lh0",  rd, 32'h00007F01);
        access(1, 0, 32'h1106, 0, 3'b101, rd, cyc);
        chk("lhu2", rd, 32'h000080FF);
        access(0, 1, 32'h1109, 32'h123456AB, 3'b000, rd, cyc);
        access(0, 1, 32'h110F, 32'hCAFEBEEF, 3'b001, rd, cyc);
        access(1, 0, 32'h1108, 0, 3'b010, rd, cyc);
        chk("sb_merge", rd, (init_word(32'h442) & 32'hFFFF00FF) | 32'h0000AB00);
        access(1, 0, 32'h110C, 0, 3'b011, rd, cyc);
        chk("sh_merge", rd, (init_word(32'h443) & 32'h0000FFFF) | 32'hBEEF0000);

        // Stalled refill holds outputs, then reset mid-refill
        ack_mode = 2;
        Addr_i   = 32'h2240;
        funct3_i = 3'b010;
        Mread_i  = 1'b1;
        Mwrite_i = 1'b0;
        #1;
        chk("stall_miss_ready", 32'(DMemReady_o), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req",   32'(MemReq_o),    32'd1);
            chk("stall_we",    32'(MemWe_o),     32'd0);
            chk("stall_addr",  MemAddr_o,        32'h2240);
            chk("stall_ready", 32'(DMemReady_o), 32'd0);
            @(negedge clk);
        end
        ack_mode = 0;
        cnt = 0;
        while (MemAddr_o !== 32'h2248 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("word2_reached", 32'(cnt < 20), 32'd1);
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_req",  32'(MemReq_o), 32'd0);
        chk("midrst_we",   32'(MemWe_o),  32'd0);
        chk("midrst_addr", MemAddr_o,     32'd0);
        rst_i   = 1'b1;
        Mread_i = 1'b0;
        model_reset();
        @(negedge clk);
        access(1, 0, 32'h2240, 0, 3'b010, rd, cyc);
        chk("rereq_miss_cyc", 32'(cyc), 32'd5);
        chk("rereq_data", rd, init_word(32'h890));
        access(1, 0, 32'h1104, 0, 3'b010, rd, cyc);
        chk("discard_dirty", rd, init_word(32'h441));

        // Random traffic against the reference model
        do_reset();
        ack_mode = 1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [2:0]  f3;
            logic [3:0]  set;
            logic [23:0] tg;
            logic        is_st;
            logic        both;
            logic        ehit;
            logic        ewb;
            logic [31:0] victim;
            int          nw;
            int          nr;
            a      = $urandom_range(0, 32'h7FF);
            wd     = $urandom;
            f3     = 3'($urandom_range(0, 7));
            both   = ($urandom_range(0, 5) == 0);
            is_st  = both || ($urandom_range(0, 1) == 1);
            set    = 4'((a / 16) % 16);
            tg     = 24'(a / 256);
            ehit   = mvalid[set] && (mtag[set] == tg);
            ewb    = !ehit && mvalid[set] && mdirty[set];
            victim = (32'(mtag[set]) * 256) + (32'(set) * 16);
            access(!is_st || both, is_st, a, wd, f3, rd, cyc);
            nw = 0;
            nr = 0;
            foreach (wl_we[i]) if (wl_we[i]) nw++; else nr++;
            if (ehit) chk("rnd_hit_cyc", 32'(cyc), 32'd0);
            else      chk("rnd_miss_cyc", 32'(cyc >= 5), 32'd1);
            chk("rnd_nwrites", 32'(nw), ewb ? 32'd4 : 32'd0);
            chk("rnd_nreads",  32'(nr), ehit ? 32'd0 : 32'd4);
            if (ewb && wl_addr.size() > 0) chk("rnd_victim", wl_addr[0], victim);
            if (is_st) begin
                ref_mem[a / 4] = ref_merge(ref_mem[a / 4], wd, f3, a[1:0]);
            end else begin
                chk("rnd_load", rd, ref_load(ref_mem[a / 4], f3, a[1:0]));
            end
            if (!ehit) begin
                mvalid[set] = 1'b1;
                mtag[set]   = tg;
                mdirty[set] = 1'b0;
            end
            if (is_st) mdirty[set] = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped lines (power of two, >=2).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port Addr_i  input  32  CPU byte address (ALU result of the EX/MEM access).
REQ-006 SHALL have port WriteD_i  input  32  CPU store data, right-aligned.
REQ-007 SHALL have port Mread_i / Mwrite_i  input  1 each  CPU load / store request.
REQ-008 SHALL have port funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port ReadD_o  output  32  load data, aligned and sign/zero-extended per funct3_i.
REQ-010 SHALL have port DMemReady_o  output  1  request complete this cycle; CPU stalls while low.
REQ-011 SHALL have ports MemAddr_o  output  32, MemWData_o  output  32, MemReq_o  output  1, MemWe_o  output  1  backing-memory word request.
REQ-012 SHALL have ports MemRData_i  input  32, MemAck_i  input  1  backing-memory read data / transfer done.

Function
REQ-013 Address split SHALL be: bits[1:0] byte, next log2(WORDS_PER_LINE) word, next log2(SETS) index, remainder tag; write-back, write-allocate policy.
REQ-014 FSM states SHALL be IDLE, WRITEBACK, REFILL; per-line state is valid, dirty, tag, data.
REQ-015 IDLE, no request: DMemReady_o=1, MemReq_o=0.
REQ-016 IDLE hit (valid and tag match): DMemReady_o=1 combinationally in the same cycle; load data on ReadD_o same cycle; store merges byte lanes and sets dirty at the clock edge.
REQ-017 Mread_i and Mwrite_i both high SHALL be treated as a store.
REQ-018 IDLE miss: DMemReady_o=0; next state WRITEBACK if victim valid and dirty, else REFILL.
REQ-019 WRITEBACK: WORDS_PER_LINE transfers, MemWe_o=1, MemAddr_o={victim tag, index, word k, 00}, MemWData_o=word k, k=0 upward; then REFILL.
REQ-020 REFILL: WORDS_PER_LINE transfers, MemWe_o=0, MemAddr_o={request tag, index, word k, 00}; each MemRData_i written into word k; after last, line valid=1, dirty=0, tag updated, go IDLE.
REQ-021 Handshake: MemReq_o, MemAddr_o, MemWe_o, MemWData_o SHALL stay stable until the cycle MemAck_i=1; k advances only on that cycle; MemAck_i with MemReq_o=0 ignored.
REQ-022 After REFILL, the returning IDLE cycle SHALL service the request as a hit; miss latency = transfers + 1 cycle (plus waits on MemAck_i).
REQ-023 CPU SHALL hold Addr_i/WriteD_i/funct3_i/requests stable while DMemReady_o=0; the block does not re-latch them.
REQ-024 SB writes lane Addr_i[1:0]; SH writes lanes by Addr_i[1] (Addr_i[0] ignored); SW ignores Addr_i[1:0]; loads extract the same lanes.
REQ-025 B/H sign-extend, BU/HU zero-extend; other funct3_i values SHALL behave as W.
REQ-026 DMemReady_o SHALL be 0 in every WRITEBACK and REFILL cycle.

Reset
REQ-027 rst_i=0 at a clock edge SHALL set state IDLE, clear every valid and dirty bit, and deassert MemReq_o and MemWe_o the following cycle, including mid-WRITEBACK/REFILL (in-flight dirty data discarded).
REQ-028 Post-reset values: DMemReady_o=1 (no request), MemReq_o=0, MemWe_o=0, MemAddr_o=0, MemWData_o=0, ReadD_o=0 with no hit; data/tag arrays not reset.

Structure
REQ-029 Package dcache_pkg SHALL hold the FSM state enum and the funct3 size/sign constants.
REQ-030 Byte-lane merge and load extract/extend SHALL be one sub-module, dcache_lane_align, shared with nothing else.

Verification
REQ-031 After reset, LW 0x100 -> 4 reads 0x100..0x10C, DMemReady_o=0 throughout, then 1 with ReadD_o=mem[0x100].
REQ-032 SW 0x104 data 0xDEADBEEF after that fill -> DMemReady_o=1 same cycle, no MemReq_o; LW 0x104 -> 0xDEADBEEF.
REQ-033 LW 0x1100 (same index, other tag) after dirty store -> 4 writes 0x100..0x10C with 0xDEADBEEF at 0x104, then 4 reads from 0x1100.
REQ-034 Word 0x80FF7F01 in cache: LB @+3 -> 0xFFFFFF80, LBU @+3 -> 0x00000080, LH @+0 -> 0x00007F01, LHU @+2 -> 0x000080FF.
REQ-035 MemAck_i held low 5 cycles in REFILL -> outputs stable, k unchanged; rst_i=0 during word 2 -> MemReq_o=0 next cycle, re-access misses.
